// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, ALU op bit indices, divider state type and a
// small sign helper for the execute stage of the 5-stage MIPS pipeline.
package ex_stage_pkg;

   localparam int DS_TO_ES_BUS_WD = 145;
   localparam int ES_TO_MS_BUS_WD = 71;
   localparam int ES_TO_DS_BUS_WD = 38;

   // alu_op is one-hot; these are the bit positions used by decode.
   localparam int ALU_OP_WD = 12;
   localparam int ALU_ADD   = 0;
   localparam int ALU_SUB   = 1;
   localparam int ALU_SLT   = 2;
   localparam int ALU_SLTU  = 3;
   localparam int ALU_AND   = 4;
   localparam int ALU_NOR   = 5;
   localparam int ALU_OR    = 6;
   localparam int ALU_XOR   = 7;
   localparam int ALU_SLL   = 8;
   localparam int ALU_SRL   = 9;
   localparam int ALU_SRA   = 10;
   localparam int ALU_LUI   = 11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   // Two's-complement negate when neg is set, pass-through otherwise.
   function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mycpu_div.sv
// mycpu_div: iterative restoring radix-2 divider, one quotient bit per cycle.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start           - begin a divide (acted on only in IDLE)
//   signed_op       - 1 for div (signed), 0 for divu
//   x, y            - dividend, divisor
//   ack             - result consumed; DONE returns to IDLE
//   done            - quotient/remainder valid
//   quotient        - signed-corrected quotient
//   remainder       - signed-corrected remainder
//   state           - current FSM state (debug visibility)
module mycpu_div
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        signed_op,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        ack,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output div_state_t  state
);

   logic [31:0] divisor;
   logic [31:0] quo;     // dividend bits shift out the top, quotient bits in the bottom
   logic [31:0] rem;
   logic [4:0]  count;
   logic        q_neg;
   logic        r_neg;
   logic [32:0] partial;
   logic [32:0] trial;

   // partial < 2*divisor, so a non-negative difference never sets bit 32;
   // bit 32 therefore acts as the borrow flag.
   always_comb begin
      partial = {rem, quo[31]};
      trial   = partial - {1'b0, divisor};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= DIV_IDLE;
         count   <= 5'd0;
         divisor <= 32'd0;
         quo     <= 32'd0;
         rem     <= 32'd0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  quo     <= neg_if(signed_op & x[31], x);
                  divisor <= neg_if(signed_op & y[31], y);
                  rem     <= 32'd0;
                  count   <= 5'd0;
                  q_neg   <= signed_op & (x[31] ^ y[31]);
                  r_neg   <= signed_op & x[31];
                  state   <= DIV_BUSY;
               end
            end
            DIV_BUSY: begin
               if (!trial[32]) begin
                  rem <= trial[31:0];
                  quo <= {quo[30:0], 1'b1};
               end else begin
                  rem <= partial[31:0];
                  quo <= {quo[30:0], 1'b0};
               end
               count <= count + 5'd1;
               if (count == 5'd31) begin
                  state <= DIV_DONE;
               end
            end
            DIV_DONE: begin
               if (ack) begin
                  state <= DIV_IDLE;
               end
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

   assign done      = (state == DIV_DONE);
   assign quotient  = neg_if(q_neg, quo);
   assign remainder = neg_if(r_neg, rem);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline. Latches the decode
// bus, evaluates ALU / multiply / divide, owns HI/LO, drives the data SRAM
// request and returns the forwarding / load-use bus to decode.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   ms_allowin        - memory stage can accept
//   es_allowin        - execute can accept
//   ds_to_es_valid    - decode bus valid
//   ds_to_es_bus      - decode -> execute bus (145 bits)
//   es_to_ms_valid    - result valid to memory stage
//   es_to_ms_bus      - {res_from_mem, gr_we, dest, result, pc}
//   es_to_ds_bus      - {load_in_es, fwd_addr, fwd_data}
//   data_sram_*       - data SRAM request (en always 1)
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ms_allowin,
   output logic                       es_allowin,
   input  logic                       ds_to_es_valid,
   input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   output logic                       es_to_ms_valid,
   output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
   output logic                       data_sram_en,
   output logic [3:0]                 data_sram_wen,
   output logic [31:0]                data_sram_addr,
   output logic [31:0]                data_sram_wdata
);

   // Handshake: a stage holds one instruction while its valid is high; it
   // accepts a new one when empty or when its current one leaves this cycle.
   // A transfer happens on an edge where sender valid and receiver allowin
   // are both high; valid never depends on the receiver's allowin.

   logic                       es_valid;
   logic [DS_TO_ES_BUS_WD-1:0] es_bus;
   logic                       es_ready_go;
   logic                       es_leave;

   logic        es_mfhi, es_mflo, es_mthi, es_mtlo;
   logic        es_divu, es_div, es_multu, es_mult;
   logic        es_src2_ze_imm;
   logic [ALU_OP_WD-1:0] es_alu_op;
   logic        es_load_op, es_src1_is_sa, es_src1_is_pc, es_src2_is_imm, es_src2_is_8;
   logic        es_gr_we, es_mem_we;
   logic [4:0]  es_dest;
   logic [15:0] es_imm;
   logic [31:0] es_rs_value, es_rt_value, es_pc;

   assign {es_mfhi, es_mflo, es_mthi, es_mtlo,
           es_divu, es_div, es_multu, es_mult,
           es_src2_ze_imm, es_alu_op,
           es_load_op, es_src1_is_sa, es_src1_is_pc, es_src2_is_imm, es_src2_is_8,
           es_gr_we, es_mem_we, es_dest, es_imm,
           es_rs_value, es_rt_value, es_pc} = es_bus;

   logic [31:0] hi, lo;
   logic [31:0] alu_src1, alu_src2, alu_result, es_result;
   logic [31:0] add_res, sub_res, sll_res, srl_res, sra_res;
   logic        slt_res, sltu_res;
   logic [4:0]  sa;
   logic [63:0] prod_s, prod_u, product;

   logic        is_div;
   logic        div_start, div_done;
   logic [31:0] div_quotient, div_remainder;
   div_state_t  div_state;

   // ---------------- pipeline register / handshake ----------------
   assign is_div         = es_div | es_divu;
   assign es_ready_go    = !is_div || div_done;
   assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
   assign es_to_ms_valid = es_valid && es_ready_go;
   assign es_leave       = es_to_ms_valid && ms_allowin;

   always_ff @(posedge clk) begin
      if (reset) begin
         es_valid <= 1'b0;
      end else if (es_allowin) begin
         es_valid <= ds_to_es_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (ds_to_es_valid && es_allowin) begin
         es_bus <= ds_to_es_bus;
      end
   end

   // ---------------- ALU ----------------
   always_comb begin
      if (es_src1_is_pc) begin
         alu_src1 = es_pc;
      end else if (es_src1_is_sa) begin
         alu_src1 = {27'd0, es_imm[10:6]};
      end else begin
         alu_src1 = es_rs_value;
      end

      if (es_src2_is_imm) begin
         alu_src2 = {{16{es_imm[15]}}, es_imm};
      end else if (es_src2_ze_imm) begin
         alu_src2 = {16'd0, es_imm};
      end else if (es_src2_is_8) begin
         alu_src2 = 32'd8;
      end else begin
         alu_src2 = es_rt_value;
      end
   end

   assign sa       = alu_src1[4:0];
   assign add_res  = alu_src1 + alu_src2;
   assign sub_res  = alu_src1 - alu_src2;
   assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
   assign sltu_res = alu_src1 < alu_src2;
   assign sll_res  = alu_src2 << sa;
   assign srl_res  = alu_src2 >> sa;
   assign sra_res  = $signed(alu_src2) >>> sa;

   // One-hot op select: OR of masked results.
   always_comb begin
      alu_result = ({32{es_alu_op[ALU_ADD ]}} & add_res)
                 | ({32{es_alu_op[ALU_SUB ]}} & sub_res)
                 | ({32{es_alu_op[ALU_SLT ]}} & {31'd0, slt_res})
                 | ({32{es_alu_op[ALU_SLTU]}} & {31'd0, sltu_res})
                 | ({32{es_alu_op[ALU_AND ]}} & (alu_src1 & alu_src2))
                 | ({32{es_alu_op[ALU_NOR ]}} & ~(alu_src1 | alu_src2))
                 | ({32{es_alu_op[ALU_OR  ]}} & (alu_src1 | alu_src2))
                 | ({32{es_alu_op[ALU_XOR ]}} & (alu_src1 ^ alu_src2))
                 | ({32{es_alu_op[ALU_SLL ]}} & sll_res)
                 | ({32{es_alu_op[ALU_SRL ]}} & srl_res)
                 | ({32{es_alu_op[ALU_SRA ]}} & sra_res)
                 | ({32{es_alu_op[ALU_LUI ]}} & {alu_src2[15:0], 16'd0});
   end

   assign es_result = es_mfhi ? hi : (es_mflo ? lo : alu_result);

   // ---------------- multiply ----------------
   // Low 64 bits of the product of sign-extended operands is the signed product.
   assign prod_s  = {{32{es_rs_value[31]}}, es_rs_value} * {{32{es_rt_value[31]}}, es_rt_value};
   assign prod_u  = {32'd0, es_rs_value} * {32'd0, es_rt_value};
   assign product = es_mult ? prod_s : prod_u;

   // ---------------- divide ----------------
   assign div_start = es_valid && is_div && (div_state == DIV_IDLE);

   mycpu_div u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .signed_op (es_div),
      .x         (es_rs_value),
      .y         (es_rt_value),
      .ack       (es_leave),
      .done      (div_done),
      .quotient  (div_quotient),
      .remainder (div_remainder),
      .state     (div_state)
   );

   // ---------------- HI/LO ----------------
   // Commit only on the leave edge so a stalled instruction writes exactly once.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (es_leave) begin
         if (es_mult || es_multu) begin
            hi <= product[63:32];
            lo <= product[31:0];
         end else if (is_div) begin
            hi <= div_remainder;
            lo <= div_quotient;
         end else begin
            if (es_mthi) hi <= es_rs_value;
            if (es_mtlo) lo <= es_rs_value;
         end
      end
   end

   // ---------------- outputs ----------------
   assign es_to_ms_bus = {es_load_op, es_gr_we, es_dest, es_result, es_pc};

   assign es_to_ds_bus = {es_valid && es_load_op,
                          (es_valid && es_gr_we) ? es_dest : 5'd0,
                          es_result};

   assign data_sram_en    = 1'b1;
   assign data_sram_wen   = (es_valid && es_mem_we) ? 4'hf : 4'h0;
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = es_rt_value;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed, table-driven bench for ex_stage plus hand-written
// sequences for multiply, HI/LO moves, divide latency, back-pressure and reset.
module tb_ex_stage;

   logic         clk;
   logic         reset;
   logic         ms_allowin;
   logic         es_allowin;
   logic         ds_to_es_valid;
   logic [144:0] ds_to_es_bus;
   logic         es_to_ms_valid;
   logic [70:0]  es_to_ms_bus;
   logic [37:0]  es_to_ds_bus;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;

   int errors = 0;
   int checks = 0;

   // flag field {mfhi,mflo,mthi,mtlo,divu,div,multu,mult,src2_ze_imm}
   localparam logic [8:0] F_NONE  = 9'h000;
   localparam logic [8:0] F_MFHI  = 9'h100;
   localparam logic [8:0] F_MFLO  = 9'h080;
   localparam logic [8:0] F_MTHI  = 9'h040;
   localparam logic [8:0] F_MTLO  = 9'h020;
   localparam logic [8:0] F_DIVU  = 9'h010;
   localparam logic [8:0] F_DIV   = 9'h008;
   localparam logic [8:0] F_MULTU = 9'h004;
   localparam logic [8:0] F_MULT  = 9'h002;
   localparam logic [8:0] F_ZE    = 9'h001;
   // misc field {load_op,src1_is_sa,src1_is_pc,src2_is_imm,src2_is_8,gr_we,mem_we}
   localparam logic [6:0] M_LOAD  = 7'b1000000;
   localparam logic [6:0] M_SA    = 7'b0100000;
   localparam logic [6:0] M_PC    = 7'b0010000;
   localparam logic [6:0] M_IMM   = 7'b0001000;
   localparam logic [6:0] M_8     = 7'b0000100;
   localparam logic [6:0] M_WE    = 7'b0000010;
   localparam logic [6:0] M_MEMWE = 7'b0000001;
   // one-hot alu_op
   localparam logic [11:0] A_ADD  = 12'h001;
   localparam logic [11:0] A_SUB  = 12'h002;
   localparam logic [11:0] A_SLT  = 12'h004;
   localparam logic [11:0] A_SLTU = 12'h008;
   localparam logic [11:0] A_AND  = 12'h010;
   localparam logic [11:0] A_NOR  = 12'h020;
   localparam logic [11:0] A_OR   = 12'h040;
   localparam logic [11:0] A_XOR  = 12'h080;
   localparam logic [11:0] A_SLL  = 12'h100;
   localparam logic [11:0] A_SRL  = 12'h200;
   localparam logic [11:0] A_SRA  = 12'h400;
   localparam logic [11:0] A_LUI  = 12'h800;

   typedef struct {
      string       name;
      logic [8:0]  fl;
      logic [11:0] alu;
      logic [6:0]  misc;
      logic [4:0]  dest;
      logic [15:0] imm;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] pc;
      logic [31:0] exp_res;
      logic        exp_load;
      logic [4:0]  exp_fwd;
      logic [3:0]  exp_wen;
   } vec_t;

   vec_t vq[$];

   ex_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ms_allowin      (ms_allowin),
      .es_allowin      (es_allowin),
      .ds_to_es_valid  (ds_to_es_valid),
      .ds_to_es_bus    (ds_to_es_bus),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .es_to_ds_bus    (es_to_ds_bus),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   function automatic logic [144:0] mk(input logic [8:0] fl, input logic [11:0] alu,
                                       input logic [6:0] misc, input logic [4:0] dest,
                                       input logic [15:0] imm, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [31:0] pc);
      return {fl, alu, misc, dest, imm, rs, rt, pc};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Present one instruction for one accepting edge, then drop valid.
   task automatic issue(input logic [144:0] b);
      int guard = 0;
      @(negedge clk);
      while (!es_allowin && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) chk("issue_allowin_timeout", {127'd0, es_allowin}, 128'd1);
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = b;
      @(posedge clk);
      #1;
      ds_to_es_valid = 1'b0;
   endtask

   task automatic read_hl(input logic is_hi, input logic [31:0] exp, input string nm);
      issue(mk(is_hi ? F_MFHI : F_MFLO, A_ADD, M_WE, 5'd2, 16'd0, 32'd0, 32'd0, 32'h100));
      chk(nm, {96'd0, es_to_ms_bus[63:32]}, {96'd0, exp});
   endtask

   // Count edges from the entry edge until es_to_ms_valid rises.
   task automatic wait_ready(input int exp_cycles, input string nm);
      int c = 0;
      while (!es_to_ms_valid && c < 60) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk(nm, 128'(c), 128'(exp_cycles));
   endtask

   task automatic add_vec(input string name, input logic [8:0] fl, input logic [11:0] alu,
                          input logic [6:0] misc, input logic [4:0] dest, input logic [15:0] imm,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] pc,
                          input logic [31:0] exp_res, input logic exp_load,
                          input logic [4:0] exp_fwd, input logic [3:0] exp_wen);
      vec_t v;
      v.name = name; v.fl = fl; v.alu = alu; v.misc = misc; v.dest = dest; v.imm = imm;
      v.rs = rs; v.rt = rt; v.pc = pc; v.exp_res = exp_res; v.exp_load = exp_load;
      v.exp_fwd = exp_fwd; v.exp_wen = exp_wen;
      vq.push_back(v);
   endtask

   // ---------------- test ----------------
   initial begin
      //       name     flags   alu     misc                    dst  imm      rs            rt            pc            result        ld  fwd  wen
      add_vec("addiu", F_NONE, A_ADD,  M_IMM|M_WE,             5'd3, 16'h0001, 32'h7FFFFFFF, 32'h0,        32'hBFC00000, 32'h80000000, 0, 5'd3, 4'h0);
      add_vec("lw",    F_NONE, A_ADD,  M_LOAD|M_IMM|M_WE,      5'd5, 16'hFFFC, 32'h00001000, 32'h0,        32'hBFC00004, 32'h00000FFC, 1, 5'd5, 4'h0);
      add_vec("sw",    F_NONE, A_ADD,  M_IMM|M_MEMWE,          5'd9, 16'h0008, 32'h00002000, 32'hDEADBEEF, 32'hBFC00008, 32'h00002008, 0, 5'd0, 4'hf);
      add_vec("subu",  F_NONE, A_SUB,  M_WE,                   5'd4, 16'h0000, 32'h00000005, 32'h00000007, 32'hBFC0000C, 32'hFFFFFFFE, 0, 5'd4, 4'h0);
      add_vec("slt",   F_NONE, A_SLT,  M_WE,                   5'd6, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 32'hBFC00010, 32'h00000001, 0, 5'd6, 4'h0);
      add_vec("sltu",  F_NONE, A_SLTU, M_WE,                   5'd7, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 32'hBFC00014, 32'h00000000, 0, 5'd7, 4'h0);
      add_vec("and",   F_NONE, A_AND,  M_WE,                   5'd8, 16'h0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hBFC00018, 32'hF000F000, 0, 5'd8, 4'h0);
      add_vec("nor",   F_NONE, A_NOR,  M_WE,                   5'd10,16'h0000, 32'hF0F0F0F0, 32'h0F0F0000, 32'hBFC0001C, 32'h00000F0F, 0, 5'd10,4'h0);
      add_vec("or",    F_NONE, A_OR,   M_WE,                   5'd11,16'h0000, 32'h12340000, 32'h00005678, 32'hBFC00020, 32'h12345678, 0, 5'd11,4'h0);
      add_vec("xori",  F_ZE,   A_XOR,  M_WE,                   5'd12,16'hFFFF, 32'h0000FF00, 32'h0,        32'hBFC00024, 32'h000000FF, 0, 5'd12,4'h0);
      add_vec("sll",   F_NONE, A_SLL,  M_SA|M_WE,              5'd13,16'h0100, 32'h0,        32'h00000001, 32'hBFC00028, 32'h00000010, 0, 5'd13,4'h0);
      add_vec("sra",   F_NONE, A_SRA,  M_SA|M_WE,              5'd14,16'h0200, 32'h0,        32'h80000000, 32'hBFC0002C, 32'hFF800000, 0, 5'd14,4'h0);
      add_vec("srl",   F_NONE, A_SRL,  M_SA|M_WE,              5'd15,16'h0200, 32'h0,        32'h80000000, 32'hBFC00030, 32'h00800000, 0, 5'd15,4'h0);
      add_vec("lui",   F_NONE, A_LUI,  M_IMM|M_WE,             5'd16,16'hABCD, 32'h0,        32'h0,        32'hBFC00034, 32'hABCD0000, 0, 5'd16,4'h0);
      add_vec("jal",   F_NONE, A_ADD,  M_PC|M_8|M_WE,          5'd31,16'h0000, 32'h0,        32'h0,        32'hBFC00010, 32'hBFC00018, 0, 5'd31,4'h0);

      // ---- reset ----
      reset          = 1'b1;
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b0;
      ds_to_es_bus   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_allowin",   {127'd0, es_allowin},     128'd1);
      chk("rst_ms_valid",  {127'd0, es_to_ms_valid}, 128'd0);
      chk("rst_wen",       {124'd0, data_sram_wen},  128'd0);
      chk("rst_ds_ctl",    {122'd0, es_to_ds_bus[37:32]}, 128'd0);
      chk("rst_sram_en",   {127'd0, data_sram_en},   128'd1);

      // ---- table of single-cycle ops ----
      for (int i = 0; i < vq.size(); i++) begin
         issue(mk(vq[i].fl, vq[i].alu, vq[i].misc, vq[i].dest, vq[i].imm,
                  vq[i].rs, vq[i].rt, vq[i].pc));
         chk({vq[i].name, ".valid"}, {127'd0, es_to_ms_valid}, 128'd1);
         chk({vq[i].name, ".ms_bus"}, {57'd0, es_to_ms_bus},
             {57'd0, vq[i].misc[6], vq[i].misc[1], vq[i].dest, vq[i].exp_res, vq[i].pc});
         chk({vq[i].name, ".ds_bus"}, {90'd0, es_to_ds_bus},
             {90'd0, vq[i].exp_load, vq[i].exp_fwd, vq[i].exp_res});
         chk({vq[i].name, ".wen"},   {124'd0, data_sram_wen},  {124'd0, vq[i].exp_wen});
         chk({vq[i].name, ".addr"},  {96'd0, data_sram_addr},  {96'd0, vq[i].exp_res});
         chk({vq[i].name, ".wdata"}, {96'd0, data_sram_wdata}, {96'd0, vq[i].rt});
      end

      // ---- HI/LO after reset, multiply, moves ----
      read_hl(1'b1, 32'h0, "mfhi_reset");
      read_hl(1'b0, 32'h0, "mflo_reset");
      issue(mk(F_MULT, 12'd0, 7'd0, 5'd0, 16'd0, 32'hFFFFFFFF, 32'h2, 32'h200));
      read_hl(1'b1, 32'hFFFFFFFF, "mult_hi");
      read_hl(1'b0, 32'hFFFFFFFE, "mult_lo");
      issue(mk(F_MULTU, 12'd0, 7'd0, 5'd0, 16'd0, 32'hFFFFFFFF, 32'h2, 32'h204));
      read_hl(1'b1, 32'h00000001, "multu_hi");
      read_hl(1'b0, 32'hFFFFFFFE, "multu_lo");
      issue(mk(F_MTHI, 12'd0, 7'd0, 5'd0, 16'd0, 32'h00000055, 32'h0, 32'h208));
      issue(mk(F_MTLO, 12'd0, 7'd0, 5'd0, 16'd0, 32'h000000AA, 32'h0, 32'h20C));
      read_hl(1'b1, 32'h00000055, "mthi_hi");
      read_hl(1'b0, 32'h000000AA, "mtlo_lo");

      // ---- div -7/2: 33-cycle latency ----
      issue(mk(F_DIV, 12'd0, 7'd0, 5'd0, 16'd0, 32'hFFFFFFF9, 32'h2, 32'h300));
      chk("div_allowin_busy", {127'd0, es_allowin},     128'd0);
      chk("div_valid_busy",   {127'd0, es_to_ms_valid}, 128'd0);
      wait_ready(33, "div_latency");
      read_hl(1'b1, 32'hFFFFFFFF, "div_hi");
      read_hl(1'b0, 32'hFFFFFFFD, "div_lo");

      // ---- divu 100/7 held by ms_allowin low for 5 extra cycles ----
      issue(mk(F_DIVU, 12'd0, 7'd0, 5'd0, 16'd0, 32'd100, 32'd7, 32'h310));
      ms_allowin = 1'b0;
      wait_ready(33, "divu_latency");
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("divu_hold_allowin", {127'd0, es_allowin},     128'd0);
      chk("divu_hold_valid",   {127'd0, es_to_ms_valid}, 128'd1);
      @(negedge clk);
      ms_allowin = 1'b1;
      @(posedge clk);
      #1;
      chk("divu_left_valid",   {127'd0, es_to_ms_valid}, 128'd0);
      chk("divu_left_allowin", {127'd0, es_allowin},     128'd1);
      read_hl(1'b1, 32'd2,  "divu_hi");
      read_hl(1'b0, 32'd14, "divu_lo");

      // ---- back-to-back divides: second starts after first leaves ----
      issue(mk(F_DIVU, 12'd0, 7'd0, 5'd0, 16'd0, 32'hFFFFFFFF, 32'h10, 32'h320));
      wait_ready(33, "b2b_first_latency");
      issue(mk(F_DIV, 12'd0, 7'd0, 5'd0, 16'd0, 32'd7, 32'hFFFFFFFE, 32'h324));
      chk("b2b_second_busy", {127'd0, es_to_ms_valid}, 128'd0);
      wait_ready(33, "b2b_second_latency");
      read_hl(1'b1, 32'h00000001, "b2b_hi");
      read_hl(1'b0, 32'hFFFFFFFD, "b2b_lo");

      // ---- reset in the middle of a divide ----
      issue(mk(F_DIV, 12'd0, 7'd0, 5'd0, 16'd0, 32'd9, 32'd2, 32'h330));
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_allowin",  {127'd0, es_allowin},     128'd1);
      chk("abort_valid",    {127'd0, es_to_ms_valid}, 128'd0);
      chk("abort_ds_ctl",   {122'd0, es_to_ds_bus[37:32]}, 128'd0);
      read_hl(1'b1, 32'h0, "abort_hi");
      read_hl(1'b0, 32'h0, "abort_lo");
      issue(mk(F_DIV, 12'd0, 7'd0, 5'd0, 16'd0, 32'd9, 32'd2, 32'h334));
      wait_ready(33, "after_abort_latency");
      read_hl(1'b1, 32'd1, "after_abort_hi");
      read_hl(1'b0, 32'd4, "after_abort_lo");

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
